// File: rtl/weight_mem_arbiter.sv
// Round-robin arbiter that lets NUM_UNITS neural units share one weight-memory
// read port. Grants are combinational. The memory request is registered, and a
// one-hot owner tag travels with each read so the returned word is routed to
// the unit that issued it.
//
// Read timing: transfer in cycle c, mem_en/mem_addr in cycle c+1, and
// rdata/rdata_valid in cycle c+1+MEM_LAT. mem_rdata is captured on the edge
// that closes cycle c+MEM_LAT. For MEM_LAT=1, the memory must present the word
// during the mem_en cycle itself.

// Per-unit bookkeeping: reports whether this unit still has a read in flight.
module weight_mem_unit_slot #(
    parameter int MEM_LAT = 1
) (
    input  logic [MEM_LAT-1:0] tag_col,
    input  logic               req,
    output logic               pending,
    output logic               req_free
);

    // A unit is pending while its owner bit sits in any tag stage.
    always_comb begin
        pending  = |tag_col;
        req_free = req & ~pending;
    end

endmodule

module weight_mem_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pause,
    input  logic [NUM_UNITS-1:0]          req,
    input  logic [NUM_UNITS*ADDR_W-1:0]   req_addr,
    output logic [NUM_UNITS-1:0]          gnt,
    output logic                          mem_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_UNITS-1:0]          rdata_valid,
    output logic                          busy
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0]                    ptr;
    logic [MEM_LAT-1:0][NUM_UNITS-1:0]   tag_pipe;
    logic [NUM_UNITS-1:0]                in_flight;
    logic [NUM_UNITS-1:0]                req_free;
    logic [NUM_UNITS-1:0]                eligible;
    logic [ADDR_W-1:0]                   addr_arr [NUM_UNITS];
    logic [PTR_W-1:0]                    win_idx;
    logic                                win_found;
    logic                                transfer;

    // Per-unit slots: unpack addresses and derive in-flight status.
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        logic [MEM_LAT-1:0] tag_col;

        for (genvar s = 0; s < MEM_LAT; s++) begin : g_col
            assign tag_col[s] = tag_pipe[s][u];
        end

        assign addr_arr[u] = req_addr[u*ADDR_W +: ADDR_W];

        weight_mem_unit_slot #(.MEM_LAT(MEM_LAT)) u_slot (
            .tag_col  (tag_col),
            .req      (req[u]),
            .pending  (in_flight[u]),
            .req_free (req_free[u])
        );
    end

    // Units with a read in flight step aside. If every requester is
    // in flight, fall back to the raw requests so a sole requester can
    // still be granted every cycle at full throughput.
    always_comb begin
        eligible = (|req_free) ? req_free : req;
    end

    // Round-robin scan starting at ptr; the first eligible unit wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    // One-hot grant, suppressed by pause and during reset.
    always_comb begin
        gnt = '0;
        if (!rst && !pause && win_found) gnt[win_idx] = 1'b1;
        transfer = |gnt;
    end

    // Priority pointer moves just past the winner on every transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (win_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    // Registered memory request; the address holds when no transfer occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_en <= transfer;
            if (transfer) mem_addr <= addr_arr[win_idx];
        end
    end

    // Owner tag pipeline, one stage per cycle of memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= gnt;
            for (int s = 1; s < MEM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // Output register: capture returning data for its owner and hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata       <= '0;
            rdata_valid <= '0;
        end else begin
            rdata_valid <= tag_pipe[MEM_LAT-1];
            if (|tag_pipe[MEM_LAT-1]) rdata <= mem_rdata;
        end
    end

    // Activity indicator for clock gating or drain checks.
    always_comb begin
        busy = (|req) | mem_en | (|in_flight);
    end

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Directed bench for weight_mem_arbiter. The main instance uses MEM_LAT=1 and
// the second instance uses MEM_LAT=3 for the reset-during-flight case. The
// memory models return a fixed function of the address, presented during the
// cycle the arbiter captures it.
module tb_weight_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pause;
    logic [3:0]  req, gnt, rdata_valid;
    logic [39:0] req_addr;
    logic        mem_en, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata, rdata;

    logic        rst3, pause3;
    logic [3:0]  req3, gnt3, rdata_valid3;
    logic [39:0] req_addr3;
    logic        mem_en3, busy3;
    logic [9:0]  mem_addr3;
    logic [31:0] mem_rdata3, rdata3;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_f(input logic [9:0] a);
        if (a == 10'h05A) return 32'hFFFF_FFF4;
        return {16'hC0DE, 6'h0, a};
    endfunction

    assign mem_rdata  = mem_f(mem_addr);
    assign mem_rdata3 = mem_f(mem_addr3);

    weight_mem_arbiter #(.NUM_UNITS(4), .ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .pause(pause), .req(req), .req_addr(req_addr),
        .gnt(gnt), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy)
    );

    weight_mem_arbiter #(.NUM_UNITS(4), .ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .pause(pause3), .req(req3), .req_addr(req_addr3),
        .gnt(gnt3), .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
        .rdata(rdata3), .rdata_valid(rdata_valid3), .busy(busy3)
    );

    // Advance to just after the next rising edge; new inputs go here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < 4; i++) req_addr[i*10 +: 10] = 10'(10'h100 + i);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1; req = 4'b0; pause = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        @(negedge clk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b want=0", mem_en); end
        total++; if (mem_addr !== 10'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=000", mem_addr); end
        total++; if (rdata_valid !== 4'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0000", rdata_valid); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        cyc();
        rst = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_first_gnt got=%b want=0001", gnt); end
        cyc();
        req = 4'b0;
        repeat (4) cyc();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g, exp_v;
        do_reset();
        set_addrs();
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req = 4'b0;
            @(negedge clk);
            exp_g = (k < 8) ? 4'(1 << (k % 4)) : 4'b0;
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt k=%0d got=%b want=%b", k, gnt, exp_g); end
            total++; if (mem_en !== (k >= 1 && k <= 8)) begin bad++; $display("FAIL rr_mem_en k=%0d got=%b", k, mem_en); end
            if (k >= 1 && k <= 8) begin
                total++; if (mem_addr !== 10'(10'h100 + (k-1) % 4)) begin bad++; $display("FAIL rr_mem_addr k=%0d got=%h", k, mem_addr); end
            end
            exp_v = (k >= 2) ? 4'(1 << ((k-2) % 4)) : 4'b0;
            total++; if (rdata_valid !== exp_v) begin bad++; $display("FAIL rr_rvalid k=%0d got=%b want=%b", k, rdata_valid, exp_v); end
            if (k >= 2) begin
                total++; if (rdata !== mem_f(10'(10'h100 + (k-2) % 4))) begin bad++; $display("FAIL rr_rdata k=%0d got=%h", k, rdata); end
            end
            cyc();
        end
    endtask

    task automatic test_single();
        do_reset();
        set_addrs();
        req_addr[20 +: 10] = 10'h05A;
        req = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        cyc(); req = 4'b0;
        @(negedge clk);
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL single_mem_en got=%b want=1", mem_en); end
        total++; if (mem_addr !== 10'h05A) begin bad++; $display("FAIL single_mem_addr got=%h want=05a", mem_addr); end
        total++; if (rdata_valid !== 4'b0) begin bad++; $display("FAIL single_early_rvalid got=%b want=0000", rdata_valid); end
        cyc();
        @(negedge clk);
        total++; if (rdata_valid !== 4'b0100) begin bad++; $display("FAIL single_rvalid got=%b want=0100", rdata_valid); end
        total++; if (rdata !== 32'hFFFF_FFF4) begin bad++; $display("FAIL single_rdata got=%h want=fffffff4", rdata); end
        cyc();
        @(negedge clk);
        total++; if (rdata_valid !== 4'b0) begin bad++; $display("FAIL single_rvalid_off got=%b want=0000", rdata_valid); end
        total++; if (rdata !== 32'hFFFF_FFF4) begin bad++; $display("FAIL single_rdata_hold got=%h want=fffffff4", rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_addrs();
        req = 4'b0001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wrap_pre_gnt got=%b want=0001", gnt); end
        cyc(); req = 4'b0;
        repeat (3) cyc();
        req = 4'b1001;
        @(negedge clk);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b want=1000", gnt); end
        cyc(); req = 4'b0001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wrap_second got=%b want=0001", gnt); end
        cyc(); req = 4'b0;
        repeat (3) cyc();
        req = 4'b0011;
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wrap_ptr_probe got=%b want=0010", gnt); end
        cyc(); req = 4'b0001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wrap_after_probe got=%b want=0001", gnt); end
        cyc(); req = 4'b0;
        repeat (3) cyc();
    endtask

    task automatic test_pause();
        do_reset();
        set_addrs();
        pause = 1'b1; req = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (gnt !== 4'b0) begin bad++; $display("FAIL pause_gnt k=%0d got=%b want=0000", k, gnt); end
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL pause_mem_en k=%0d got=%b want=0", k, mem_en); end
            cyc();
        end
        pause = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL pause_release got=%b want=0010", gnt); end
        cyc(); req = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL pause_next got=%b want=0100", gnt); end
        total++; if (mem_addr !== 10'h101) begin bad++; $display("FAIL pause_mem_addr got=%h want=101", mem_addr); end
        cyc(); req = 4'b0;
        repeat (3) cyc();
    endtask

    task automatic test_drop();
        do_reset();
        set_addrs();
        req = 4'b0011;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_gnt got=%b want=0001", gnt); end
        cyc(); req = 4'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            total++; if (gnt !== 4'b0) begin bad++; $display("FAIL drop_late_gnt j=%0d got=%b want=0000", j, gnt); end
            total++; if (rdata_valid !== ((j == 1) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL drop_rvalid j=%0d got=%b", j, rdata_valid); end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_addrs();
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) req = 4'b0;
            @(negedge clk);
            total++; if (gnt !== ((k < 3) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL b2b_gnt k=%0d got=%b", k, gnt); end
            total++; if (rdata_valid !== ((k >= 2) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL b2b_rvalid k=%0d got=%b", k, rdata_valid); end
            cyc();
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset_flight();
        for (int i = 0; i < 4; i++) req_addr3[i*10 +: 10] = 10'(10'h100 + i);
        req3 = 4'b0011;
        @(negedge clk);
        total++; if (gnt3 !== 4'b0001) begin bad++; $display("FAIL flight_gnt0 got=%b want=0001", gnt3); end
        cyc(); req3 = 4'b0010;
        @(negedge clk);
        total++; if (gnt3 !== 4'b0010) begin bad++; $display("FAIL flight_gnt1 got=%b want=0010", gnt3); end
        cyc(); req3 = 4'b0; rst3 = 1'b1;
        @(negedge clk);
        total++; if (mem_en3 !== 1'b0) begin bad++; $display("FAIL flight_rst_mem_en got=%b want=0", mem_en3); end
        cyc(); rst3 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            total++; if (rdata_valid3 !== 4'b0) begin bad++; $display("FAIL flight_rvalid j=%0d got=%b want=0000", j, rdata_valid3); end
            total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL flight_busy j=%0d got=%b want=0", j, busy3); end
            cyc();
        end
        req3 = 4'b0011;
        @(negedge clk);
        total++; if (gnt3 !== 4'b0001) begin bad++; $display("FAIL flight_ptr_cleared got=%b want=0001", gnt3); end
        cyc(); req3 = 4'b0;
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; req = 4'b0; req_addr = '0;
        rst3 = 1'b1; pause3 = 1'b0; req3 = 4'b0; req_addr3 = '0;
        repeat (2) cyc();
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_pause();
        test_drop();
        test_back_to_back();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
